mux_rr_arbiter: RTL and testbench
=================================

// Module: mux_rr_arbiter
// PURPOSE
//   Upstream control stage for the 4:1 single-bit mux. Four sources raise requests.
//   The block picks one source in round-robin order and drives the mux select from
//   that choice. It also drives a one-hot grant so the chosen source knows it owns
//   the mux output.
//   A hold limit stops one requester from starving the others.
// PARAMETERS
//   HOLD_MAX  4  max consecutive grant cycles while another req pending; legal >=1
// PORTS
//   clk          in   1  rising-edge clock
//   rst_n        in   1  asynchronous, active-low reset
//   req          in   4  request per mux input; bit0=a, bit1=b, bit2=c, bit3=d
//   select       out  2  mux select; connects directly to the mux select port
//   grant        out  4  one-hot grant; equals (1<<select) when grant_valid, else 0
//   grant_valid  out  1  a grant is active this cycle
//   hold_cnt     out  W  cycles current owner has held grant; W=$clog2(HOLD_MAX+1)
// BEHAVIOUR
//   Reset (async assert, sync release) clears outputs and state:
//     select=2'd0, grant=4'b0, grant_valid=0, hold_cnt=0.
//     last_owner=2'd3, so requester 0 has first priority. State=IDLE.
//   All outputs are registered. Latency from req to grant is 1 cycle.
//   Round-robin pick: scan last_owner+1, +2, +3, +4 (mod 4); the first set req bit wins.
//     The current owner is therefore checked last.
//   FSM states:
//     IDLE  -> GRANT when req!=0.
//              Load select=pick, set grant_valid=1, hold_cnt=1, last_owner=pick.
//     GRANT, cases on req[select] and the other req bits:
//       req[select]=0, others 0   -> IDLE.
//            grant_valid=0, grant=0; select HOLDS its last value so the mux
//            output stays stable; hold_cnt=0.
//       req[select]=0, others !=0 -> stay GRANT.
//            Switch directly to pick (no bubble cycle); hold_cnt=1.
//       req[select]=1, others 0   -> stay GRANT with the same owner.
//            hold_cnt saturates at HOLD_MAX.
//       req[select]=1, others !=0, hold_cnt<HOLD_MAX -> keep owner, hold_cnt+1.
//       req[select]=1, others !=0, hold_cnt==HOLD_MAX -> forced switch to pick.
//            hold_cnt=1.
//   Boundary cases:
//     - Simultaneous release and new request: handled by the direct-switch case;
//       no idle cycle is inserted.
//     - Only the owner requesting after hitting HOLD_MAX: the owner keeps the grant.
//     - Wrap-around: last_owner=3 makes requester 0 next in priority.
//     - Reset mid-grant: grant and grant_valid drop asynchronously within the
//       same cycle.
//   Invariants:
//     - grant is always one-hot or zero.
//     - grant!=0 exactly when grant_valid=1.
//     - select changes only on a grant transition.
// STRUCTURE
//   Package mux_arb_pkg holds:
//     localparam NUM_REQ=4 and SEL_W=2;
//     typedef enum logic {IDLE, GRANT} arb_state_t.
//   Sub-module rr_pick is purely combinational.
//     Inputs: req[3:0], last[1:0]. Outputs: pick[1:0], any.
//     It implements the rotate-and-priority scan and is reusable by other arbiters.
//   Top level holds the FSM, the hold counter, last_owner and the output registers.
// TESTING
//   1) Reset with req=4'b1111.
//      -> select=0, grant=0, grant_valid=0.
//      -> First edge after reset release: grant=4'b0001.
//   2) Single requester: req=4'b0100 for 6 cycles, then 0.
//      -> Edge 1 onward: select=2, grant=4'b0100.
//      -> hold_cnt runs 1,2,3,4,4,4.
//      -> After release: grant_valid=0 and select stays 2.
//   3) Fairness: req=4'b1111 held with HOLD_MAX=4.
//      -> Owners cycle 0,1,2,3,0, each for exactly 4 cycles.
//      -> Check with a scoreboard driving a,b,c,d=grant-indexed data into the mux;
//         mux out must match the data of the granted source.
//   4) Direct switch: owner 1 drops req on the same cycle req[3] rises.
//      -> Next edge: select=3, grant=4'b1000, hold_cnt=1.
//      -> grant_valid never deasserts.
//   5) Wrap-around: last_owner=3 with req=4'b1001.
//      -> Next grant goes to 0, not 3.
//   6) Async reset pulsed mid-grant (select=2).
//      -> grant=0 and grant_valid=0 before the next clock edge.
//      -> After release with req=4'b0100: requester 2 is granted again.

Source files
------------

// File: rtl/mux_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_arb_pkg
// Description : Shared types and constants for the 4:1 mux round-robin
//               arbiter and its combinational picker.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Expand a select index into the matching one-hot grant vector.
    function automatic logic [NUM_REQ-1:0] sel_to_onehot(input logic [SEL_W-1:0] sel);
        logic [NUM_REQ-1:0] oh;
        oh      = '0;
        oh[sel] = 1'b1;
        return oh;
    endfunction

endpackage : mux_arb_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin scan. Starting one past the last
//               owner, returns the first asserted request; the last owner is
//               considered only after every other source.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   last,
    output logic [SEL_W-1:0]   pick,
    output logic               any
);

    // Rotating priority scan: last+1, last+2, last+3, then last itself.
    always_comb begin
        logic [SEL_W-1:0] idx;
        logic             found;
        pick  = '0;
        any   = |req;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = last + SEL_W'(i);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux_rr_arbiter
// Description : Round-robin arbiter driving the select of a 4:1 single-bit
//               mux, with a one-hot grant and a hold limit that bounds how
//               long one owner may keep the mux while others are waiting.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int HOLD_MAX = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req,
    output logic [SEL_W-1:0]                select,
    output logic [NUM_REQ-1:0]              grant,
    output logic                            grant_valid,
    output logic [$clog2(HOLD_MAX+1)-1:0]   hold_cnt
);

    localparam int              HOLD_W     = $clog2(HOLD_MAX + 1);
    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(HOLD_MAX);

    arb_state_t          state_q,       state_d;
    logic [SEL_W-1:0]    select_q,      select_d;
    logic [NUM_REQ-1:0]  grant_q,       grant_d;
    logic                grant_valid_q, grant_valid_d;
    logic [HOLD_W-1:0]   hold_cnt_q,    hold_cnt_d;
    logic [SEL_W-1:0]    last_owner_q,  last_owner_d;

    logic [SEL_W-1:0]    pick;
    logic                any_req;
    logic                owner_req;
    logic                others_req;

    rr_pick u_rr_pick (
        .req  (req),
        .last (last_owner_q),
        .pick (pick),
        .any  (any_req)
    );

    // Split requests into the current owner's bit and everyone else.
    always_comb begin
        owner_req  = req[select_q];
        others_req = |(req & ~sel_to_onehot(select_q));
    end

    // Next-state and registered-output computation for the arbitration FSM.
    always_comb begin
        state_d       = state_q;
        select_d      = select_q;
        grant_valid_d = grant_valid_q;
        hold_cnt_d    = hold_cnt_q;
        last_owner_d  = last_owner_q;

        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d       = GRANT;
                    select_d      = pick;
                    grant_valid_d = 1'b1;
                    hold_cnt_d    = HOLD_W'(1);
                    last_owner_d  = pick;
                end
            end
            GRANT: begin
                if (!owner_req && !others_req) begin
                    // Nobody wants the mux: drop the grant but leave select
                    // alone so the mux output does not glitch.
                    state_d       = IDLE;
                    grant_valid_d = 1'b0;
                    hold_cnt_d    = '0;
                end else if (!owner_req) begin
                    // Owner released while others wait: hand over directly.
                    select_d      = pick;
                    hold_cnt_d    = HOLD_W'(1);
                    last_owner_d  = pick;
                end else if (!others_req) begin
                    // Uncontested owner keeps the mux; count saturates.
                    if (hold_cnt_q < HOLD_LIMIT) begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end else if (hold_cnt_q < HOLD_LIMIT) begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end else begin
                    // Hold limit reached with contenders: force a switch.
                    // The owner is scanned last, so pick is another source.
                    select_d      = pick;
                    hold_cnt_d    = HOLD_W'(1);
                    last_owner_d  = pick;
                end
            end
            default: begin
                state_d       = IDLE;
                grant_valid_d = 1'b0;
                hold_cnt_d    = '0;
            end
        endcase

        grant_d = grant_valid_d ? sel_to_onehot(select_d) : '0;
    end

    // State and output registers; async assert, release sync to clk upstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            select_q      <= '0;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            hold_cnt_q    <= '0;
            last_owner_q  <= SEL_W'(NUM_REQ - 1);
        end else begin
            state_q       <= state_d;
            select_q      <= select_d;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            hold_cnt_q    <= hold_cnt_d;
            last_owner_q  <= last_owner_d;
        end
    end

    assign select      = select_q;
    assign grant       = grant_q;
    assign grant_valid = grant_valid_q;
    assign hold_cnt    = hold_cnt_q;

endmodule : mux_rr_arbiter
`default_nettype wire

// File: tb/tb_mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_rr_arbiter
// Description : Self-checking bench for mux_rr_arbiter. Expected outputs are
//               queued when a request pattern is driven and compared after
//               the following clock edge, including the data seen through a
//               bench-side 4:1 mux driven by the arbiter's select.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_rr_arbiter;

    localparam int HOLD_MAX = 4;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

    logic              clk;
    logic              rst_n;
    logic [3:0]        req;
    logic [1:0]        select;
    logic [3:0]        grant;
    logic              grant_valid;
    logic [HOLD_W-1:0] hold_cnt;

    logic [3:0]        mux_data;
    logic              mux_out;

    typedef struct {
        logic [1:0]        sel;
        logic [3:0]        gnt;
        logic              gv;
        logic [HOLD_W-1:0] hold;
        logic              data;
    } exp_t;

    exp_t exp_q[$];

    int n_tests;
    int n_fail;

    mux_rr_arbiter #(
        .HOLD_MAX (HOLD_MAX)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .select      (select),
        .grant       (grant),
        .grant_valid (grant_valid),
        .hold_cnt    (hold_cnt)
    );

    // The downstream mux the arbiter steers.
    assign mux_out = mux_data[select];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive a request pattern, queue the expected post-edge outputs, then
    // pop and compare once the edge has happened.
    task automatic step(input string tag, input logic [3:0] r,
                        input logic [1:0] e_sel, input logic [3:0] e_gnt,
                        input logic e_gv, input int e_hold);
        exp_t e;
        logic [3:0] d;
        d          = 4'($urandom);
        req        = r;
        mux_data   = d;
        e.sel      = e_sel;
        e.gnt      = e_gnt;
        e.gv       = e_gv;
        e.hold     = HOLD_W'(e_hold);
        e.data     = d[e_sel];
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check({tag, ".select"},   32'(select),      32'(e.sel));
        check({tag, ".grant"},    32'(grant),       32'(e.gnt));
        check({tag, ".valid"},    32'(grant_valid), 32'(e.gv));
        check({tag, ".hold_cnt"}, 32'(hold_cnt),    32'(e.hold));
        if (e.gv) begin
            check({tag, ".mux_out"}, 32'(mux_out), 32'(e.data));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        req      = 4'b1111;
        mux_data = 4'b0;

        // 1) Reset with all requesting.
        repeat (2) @(posedge clk);
        #1;
        check("rst.select",   32'(select),      32'd0);
        check("rst.grant",    32'(grant),       32'd0);
        check("rst.valid",    32'(grant_valid), 32'd0);
        check("rst.hold_cnt", 32'(hold_cnt),    32'd0);
        rst_n = 1'b1;
        step("first", 4'b1111, 2'd0, 4'b0001, 1'b1, 1);
        step("first_rel", 4'b0000, 2'd0, 4'b0000, 1'b0, 0);

        // 2) Single requester, saturating hold count, then release.
        for (int k = 0; k < 6; k++) begin
            step($sformatf("single%0d", k), 4'b0100, 2'd2, 4'b0100, 1'b1,
                 (k < HOLD_MAX) ? k + 1 : HOLD_MAX);
        end
        step("single_rel", 4'b0000, 2'd2, 4'b0000, 1'b0, 0);

        // 3) Fairness under full contention from a fresh reset.
        do_reset();
        for (int k = 0; k < 5 * HOLD_MAX; k++) begin
            logic [1:0] own;
            own = 2'((k / HOLD_MAX) % 4);
            step($sformatf("fair%0d", k), 4'b1111, own, 4'b0001 << own, 1'b1,
                 (k % HOLD_MAX) + 1);
        end

        // 4) Direct switch: hand to 1, then 1 drops as 3 rises.
        step("to_owner1", 4'b0010, 2'd1, 4'b0010, 1'b1, 1);
        step("to_owner1b", 4'b0010, 2'd1, 4'b0010, 1'b1, 2);
        step("direct_sw", 4'b1000, 2'd3, 4'b1000, 1'b1, 1);

        // 5) Wrap-around: idle with last owner 3, then requesters 0 and 3.
        step("idle3", 4'b0000, 2'd3, 4'b0000, 1'b0, 0);
        step("wrap", 4'b1001, 2'd0, 4'b0001, 1'b1, 1);

        // 6) Async reset mid-grant while requester 2 owns the mux.
        step("to_owner2", 4'b0100, 2'd2, 4'b0100, 1'b1, 1);
        step("to_owner2b", 4'b0100, 2'd2, 4'b0100, 1'b1, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async.grant", 32'(grant),       32'd0);
        check("async.valid", 32'(grant_valid), 32'd0);
        check("async.select", 32'(select),     32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("post_rst", 4'b0100, 2'd2, 4'b0100, 1'b1, 1);

        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_mux_rr_arbiter
`default_nettype wire
